// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring plus HALT, decoded into the control word.
// Optional macro SAP1_CTRL_EARLY_END_EN returns to T1 right after an instruction's last active T-state.
module sap1_controller #(
    parameter int unsigned T_STATES = 6
) (
    input  logic                i_clk,
    input  logic                i_clr_n,
    input  logic                i_run,
    input  logic [3:0]          i_opcode,
    output logic                o_clr,
    output logic                o_cp,
    output logic                o_ep,
    output logic                o_lm,
    output logic                o_ce,
    output logic                o_li,
    output logic                o_ei,
    output logic                o_la,
    output logic                o_ea,
    output logic                o_su,
    output logic                o_eu,
    output logic                o_lb,
    output logic                o_lo,
    output logic                o_hlt,
    output logic [T_STATES-1:0] o_t_state
);

    localparam int unsigned SW       = T_STATES + 1;
    localparam int unsigned HALT_BIT = T_STATES;
    localparam int unsigned T1       = 0;
    localparam int unsigned T2       = 1;
    localparam int unsigned T3       = 2;
    localparam int unsigned T4       = 3;
    localparam int unsigned T5       = 4;
    localparam int unsigned T6       = 5;

    localparam logic [SW-1:0] S_T1   = SW'(1);
    localparam logic [SW-1:0] S_HALT = SW'(1) << HALT_BIT;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          last_step_c;

    // Early termination: the current T-state is the final active one of its instruction.
`ifdef SAP1_CTRL_EARLY_END_EN
    always_comb begin
        last_step_c = 1'b0;
        if (state_q[T4] && !(i_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT}))
            last_step_c = 1'b1;
        if (state_q[T5] && (i_opcode == OP_LDA))
            last_step_c = 1'b1;
    end
`else
    assign last_step_c = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_clr_n)
            state_q <= S_T1;
        else
            state_q <= state_d;
    end

    // Ring advance; HALT is absorbing and only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (i_run) begin
            if (state_q[HALT_BIT])
                state_d = S_HALT;
            else if (state_q[T4] && (i_opcode == OP_HLT))
                state_d = S_HALT;
            else if (last_step_c)
                state_d = S_T1;
            else
                state_d = {1'b0, state_q[T_STATES-2:0], state_q[T_STATES-1]};
        end
    end

    always_comb begin
        o_clr = ~i_clr_n;
        o_cp  = 1'b0;
        o_ep  = 1'b0;
        o_lm  = 1'b0;
        o_ce  = 1'b0;
        o_li  = 1'b0;
        o_ei  = 1'b0;
        o_la  = 1'b0;
        o_ea  = 1'b0;
        o_su  = 1'b0;
        o_eu  = 1'b0;
        o_lb  = 1'b0;
        o_lo  = 1'b0;
        o_hlt = 1'b0;
        // Reset masks the whole control word, HALT included.
        if (i_clr_n) begin
            if (state_q[HALT_BIT]) begin
                o_hlt = 1'b1;
            end else if (state_q[T1]) begin
                o_ep = 1'b1;
                o_lm = 1'b1;
            end else if (state_q[T2]) begin
                o_cp = 1'b1;
            end else if (state_q[T3]) begin
                o_ce = 1'b1;
                o_li = 1'b1;
            end else if (state_q[T4]) begin
                if (i_opcode inside {OP_LDA, OP_ADD, OP_SUB}) begin
                    o_ei = 1'b1;
                    o_lm = 1'b1;
                end else if (i_opcode == OP_OUT) begin
                    o_ea = 1'b1;
                    o_lo = 1'b1;
                end else if (i_opcode == OP_HLT) begin
                    o_hlt = 1'b1;
                end
            end else if (state_q[T5]) begin
                if (i_opcode == OP_LDA) begin
                    o_ce = 1'b1;
                    o_la = 1'b1;
                end else if (i_opcode inside {OP_ADD, OP_SUB}) begin
                    o_ce = 1'b1;
                    o_lb = 1'b1;
                    o_su = (i_opcode == OP_SUB);
                end
            end else if (state_q[T6]) begin
                if (i_opcode inside {OP_ADD, OP_SUB}) begin
                    o_eu = 1'b1;
                    o_la = 1'b1;
                    o_su = (i_opcode == OP_SUB);
                end
            end
        end
    end

    assign o_t_state = state_q[T_STATES-1:0];

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: per-scenario tasks checked against a table-driven
// instruction model; honours SAP1_CTRL_EARLY_END_EN when computing instruction lengths.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       run;
    logic [3:0] opcode;
    logic       o_clr, o_cp, o_ep, o_lm, o_ce, o_li, o_ei;
    logic       o_la, o_ea, o_su, o_eu, o_lb, o_lo, o_hlt;
    logic [5:0] t_state;
    logic [12:0] ctrl;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    sap1_controller dut (
        .i_clk     (clk),
        .i_clr_n   (clr_n),
        .i_run     (run),
        .i_opcode  (opcode),
        .o_clr     (o_clr),
        .o_cp      (o_cp),
        .o_ep      (o_ep),
        .o_lm      (o_lm),
        .o_ce      (o_ce),
        .o_li      (o_li),
        .o_ei      (o_ei),
        .o_la      (o_la),
        .o_ea      (o_ea),
        .o_su      (o_su),
        .o_eu      (o_eu),
        .o_lb      (o_lb),
        .o_lo      (o_lo),
        .o_hlt     (o_hlt),
        .o_t_state (t_state)
    );

    assign ctrl = {o_cp, o_ep, o_lm, o_ce, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo, o_hlt};

    // Expected control word for T-step 1..6 of instruction op, packed like ctrl.
    function automatic logic [12:0] exp_ctrl(input int step, input logic [3:0] op);
        logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
        logic mem_op, alu_op;
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt} = 13'd0;
        mem_op = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
        alu_op = (op == 4'h1) || (op == 4'h2);
        case (step)
            1: begin ep = 1'b1; lm = 1'b1; end
            2: cp = 1'b1;
            3: begin ce = 1'b1; li = 1'b1; end
            4: begin
                if (mem_op) begin ei = 1'b1; lm = 1'b1; end
                if (op == 4'hE) begin ea = 1'b1; lo = 1'b1; end
                if (op == 4'hF) hlt = 1'b1;
            end
            5: begin
                if (op == 4'h0) begin ce = 1'b1; la = 1'b1; end
                if (alu_op) begin ce = 1'b1; lb = 1'b1; su = (op == 4'h2); end
            end
            6: if (alu_op) begin eu = 1'b1; la = 1'b1; su = (op == 4'h2); end
            default: ;
        endcase
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};
    endfunction

    function automatic int instr_len(input logic [3:0] op);
        if (op == 4'hF) return 4;
`ifdef SAP1_CTRL_EARLY_END_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction starting in T1; optional stall at stall_step, optional reset at abort_step.
    task automatic run_instr(input logic [3:0] op, input int stall_step, input int stall_n,
                             input int abort_step);
        int len;
        int reps;
        logic [5:0] exp_t;
        int n_drv;
        len = instr_len(op);
        for (int step = 1; step <= len; step++) begin
            exp_t = 6'(1 << (step - 1));
            if (step == abort_step) begin
                opcode = (step >= 4) ? op : 4'($urandom);
                run    = 1'($urandom);
                clr_n  = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (ctrl !== 13'd0 || o_clr !== 1'b1) begin
                    n_bad++;
                    $display("FAIL abort_ctrl op=%h step=%0d got ctrl=%h clr=%b want ctrl=0000 clr=1",
                             op, step, ctrl, o_clr);
                end
                n_cmp++;
                if (t_state !== exp_t) begin
                    n_bad++;
                    $display("FAIL abort_state op=%h step=%0d got %h want %h", op, step, t_state, exp_t);
                end
                cycle();
                clr_n = 1'b1;
                return;
            end
            reps = (step == stall_step) ? stall_n : 0;
            for (int s = 0; s <= reps; s++) begin
                run    = (s < reps) ? 1'b0 : 1'b1;
                opcode = (step >= 4) ? op : 4'($urandom);
                @(negedge clk);
                n_cmp++;
                if (t_state !== exp_t) begin
                    n_bad++;
                    $display("FAIL t_state op=%h step=%0d got %h want %h", op, step, t_state, exp_t);
                end
                n_cmp++;
                if (ctrl !== exp_ctrl(step, op) || o_clr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ctrl op=%h step=%0d got %h clr=%b want %h clr=0",
                             op, step, ctrl, o_clr, exp_ctrl(step, op));
                end
                n_drv = int'(o_ep) + int'(o_ce) + int'(o_ei) + int'(o_ea) + int'(o_eu);
                n_cmp++;
                if (n_drv > 1) begin
                    n_bad++;
                    $display("FAIL bus_drivers op=%h step=%0d got %0d want <=1", op, step, n_drv);
                end
                cycle();
            end
        end
        n_cmp++;
        if (t_state !== ((op == 4'hF) ? 6'h00 : 6'h01)) begin
            n_bad++;
            $display("FAIL end_state op=%h got %h want %h", op, t_state,
                     (op == 4'hF) ? 6'h00 : 6'h01);
        end
    endtask

    task automatic test_reset();
        clr_n  = 1'b0;
        run    = 1'b0;
        opcode = 4'h0;
        cycle();
        cycle();
        @(negedge clk);
        n_cmp++;
        if (ctrl !== 13'd0 || o_clr !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl got ctrl=%h clr=%b want ctrl=0000 clr=1", ctrl, o_clr);
        end
        n_cmp++;
        if (t_state !== 6'h01) begin
            n_bad++;
            $display("FAIL reset_state got %h want 01", t_state);
        end
        cycle();
        clr_n = 1'b1;
    endtask

    task automatic test_lda();
        run_instr(4'h0, 0, 0, 0);
    endtask

    task automatic test_sub();
        run_instr(4'h2, 0, 0, 0);
    endtask

    task automatic test_run_hold();
        run_instr(4'h1, 2, 3, 0);
    endtask

    task automatic test_clr_mid();
        run_instr(4'h1, 0, 0, 5);
        run_instr(4'h0, 0, 0, 0);
    endtask

    task automatic test_hlt();
        run_instr(4'hF, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            run    = 1'($urandom);
            opcode = 4'($urandom);
            @(negedge clk);
            n_cmp++;
            if (t_state !== 6'h00 || ctrl !== 13'h0001) begin
                n_bad++;
                $display("FAIL halt_hold cyc=%0d got t=%h ctrl=%h want t=00 ctrl=0001", i, t_state, ctrl);
            end
            cycle();
        end
        clr_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== 13'd0 || o_clr !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_clr_ctrl got ctrl=%h clr=%b want ctrl=0000 clr=1", ctrl, o_clr);
        end
        cycle();
        clr_n = 1'b1;
        n_cmp++;
        if (t_state !== 6'h01) begin
            n_bad++;
            $display("FAIL halt_exit got %h want 01", t_state);
        end
    endtask

    task automatic test_early_end();
        logic [3:0] ops [2];
        int cnt;
        ops[0] = 4'hE;
        ops[1] = 4'h0;
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            do begin
                run    = 1'b1;
                opcode = (cnt >= 3) ? ops[k] : 4'($urandom);
                cycle();
                cnt++;
            end while (t_state !== 6'h01 && cnt < 12);
            n_cmp++;
            if (cnt != instr_len(ops[k])) begin
                n_bad++;
                $display("FAIL instr_cycles op=%h got %0d want %0d", ops[k], cnt, instr_len(ops[k]));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        int abort;
        for (int i = 0; i < 40; i++) begin
            op    = 4'($urandom_range(0, 14));
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, instr_len(op))) : 0;
            run_instr(op, int'($urandom_range(1, 8)), int'($urandom_range(1, 3)), abort);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub();
        test_run_hold();
        test_clr_mid();
        test_early_end();
        test_random();
        test_hlt();
        test_lda();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
